mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Iterative HI/LO multiply/divide unit in the EX stage, directly downstream of the register-file read ports.
//  Consumes rs/rt operands (Read_data1/Read_data2) and computes MULT/MULTU/DIV/DIVU into HI/LO over
//  multiple cycles. Also handles MTHI/MTLO. HI/LO feed MFHI/MFLO back toward the register-file write path.
//  Pipeline control stalls on busy.
// PARAMETERS
//  WIDTH  32  operand width; HI/LO are WIDTH each; product/remainder datapath is 2*WIDTH
// PORTS
//  clk        in   1      clock; all state updates on the rising edge
//  reset      in   1      synchronous, active-low reset; sampled on the clk rising edge
//  start      in   1      request; accepted only when busy==0
//  op         in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others = no-op
//  operand_a  in   WIDTH  rs value (multiplicand / dividend / MTHI-MTLO data)
//  operand_b  in   WIDTH  rt value (multiplier / divisor)
//  abort      in   1      present only with MDU_ABORT_EN
//  busy       out  1      operation in flight; stage must stall
//  done       out  1      one-cycle pulse; HI/LO updated this cycle
//  hi         out  WIDTH  HI register
//  lo         out  WIDTH  LO register
// BEHAVIOUR
//  Reset (reset==0 at edge): state IDLE; busy=0, done=0, hi=0, lo=0, counter=0. Wins over every other input.
//  FSM states: IDLE -> RUN (WIDTH iterations) -> FIX -> IDLE. DIVZ is a one-cycle path: IDLE -> FIX.
//  Edge E0, IDLE, start=1, op in MULT..DIVU:
//    - latch |a| and |b| (magnitudes only for signed ops);
//    - latch result signs: quotient/product = sa^sb, remainder = sa;
//    - counter=0; state=RUN; busy=1 from the next cycle.
//  RUN, edges E1..E(WIDTH): one radix-2 step per edge.
//    - Multiply: shift-add.
//    - Divide: restoring shift-subtract.
//    - counter increments; at counter==WIDTH-1 the next state is FIX.
//  FIX, edge E(WIDTH+1):
//    - apply two's-complement sign correction;
//    - write hi/lo; done=1 and busy=0 in the following cycle; state=IDLE.
//  Total latency: start cycle to done cycle = WIDTH+2 cycles (34 at default). hi/lo are stable otherwise.
//  start while busy=1: ignored, no queuing. start in the done cycle: accepted (back-to-back).
//  MTHI/MTLO in IDLE: single-cycle write of operand_a to hi/lo at E0. busy stays 0; done stays 0.
//  Undefined op with start=1: no state change.
//  Results:
//    - MULT/MULTU: {hi,lo} = 2*WIDTH-bit product.
//    - DIV/DIVU: lo = quotient (truncated toward zero), hi = remainder (sign of dividend).
//  Divide by zero: skip RUN; next edge goes to FIX. Result lo = all-ones, hi = operand_a. Latency 2 cycles.
//  Signed overflow, DIV 0x80000000 / -1: lo = 0x80000000, hi = 0 (natural result of the magnitude datapath).
//  Reset mid-operation: returns to IDLE, clears hi/lo, no done pulse.
// CONFIGURATION
//  MDU_ABORT_EN defined:
//    - abort port exists;
//    - abort=1 in RUN/FIX returns to IDLE on that edge; busy=0 next cycle;
//    - hi/lo unchanged, no done pulse;
//    - abort in IDLE is ignored; abort has priority over start in the same cycle.
//  MDU_ABORT_EN undefined: no abort port; every accepted operation runs to completion.
// STRUCTURE
//  Shared package mdu_pkg:
//    - op encodings (MDU_OP_MULT..MDU_OP_MTLO);
//    - FSM state encodings (IDLE, RUN, FIX);
//    - iteration-count constant.
//  One sub-module, mdu_div_step: combinational restoring-divide step.
//    - in: partial remainder, divisor;
//    - out: next partial remainder, quotient bit.
//  Multiply step, counter, sign fix and FSM stay inline.
// TESTING
//  Check cycle counts, hi/lo and the busy/done waveform against a behavioural model in every scenario.
//  1. MULTU 7 x 6: hi=0, lo=42; done exactly 34 cycles after start; busy high for 33 cycles.
//  2. MULT -3 x 5: hi=0xFFFFFFFF, lo=0xFFFFFFF1.
//     MULT 0x80000000 x 0x80000000: hi=0x40000000, lo=0.
//  3. DIVU 100/7: lo=14, hi=2.
//     DIV -7/2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     DIV 0x80000000/-1: lo=0x80000000, hi=0.
//  4. DIV 5/0: lo=0xFFFFFFFF, hi=5; done 2 cycles after start.
//  5. start held high throughout MULT 2x3: second request ignored until the done cycle, then accepted;
//     MTLO 0x1234 while idle: lo=0x1234 next cycle, done=0.
//  6. reset=0 at iteration 10: hi=lo=0, busy=0, no done pulse.
//     With MDU_ABORT_EN, abort at iteration 10: prior hi/lo kept, no done pulse.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: op codes, FSM states, iteration count.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package mdu_pkg;

    localparam int MDU_ITERS = 32;

    typedef enum logic [2:0] {
        MDU_OP_MULT  = 3'b000,
        MDU_OP_MULTU = 3'b001,
        MDU_OP_DIV   = 3'b010,
        MDU_OP_DIVU  = 3'b011,
        MDU_OP_MTHI  = 3'b100,
        MDU_OP_MTLO  = 3'b101
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_RUN  = 2'b01,
        MDU_FIX  = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-divide step: trial-subtract divisor from the shifted partial remainder.
// Latency: combinational.
// Backpressure: none.
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   part_rem,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);

    logic [WIDTH-1:0] diff;

    // When the subtraction succeeds the true difference is below the divisor, so W bits suffice.
    always_comb begin
        q_bit    = (part_rem >= {1'b0, divisor});
        diff     = part_rem[WIDTH-1:0] - divisor;
        next_rem = q_bit ? diff : part_rem[WIDTH-1:0];
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit (radix-2); optional abort port under MDU_ABORT_EN.
// Latency: WIDTH+2 cycles start-to-done (2 for divide by zero); MTHI/MTLO write in one cycle.
// Backpressure: busy high while an operation is in flight; start is ignored, not queued.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_ITERS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
`ifdef MDU_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    mdu_state_e           state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 is_div_q, is_div_d, divz_q, divz_d;
    logic                 qsign_q, qsign_d, rsign_q, rsign_d, done_q, done_d;

    logic                 abort_req;
    logic                 op_signed, sa, sb;
    logic [WIDTH-1:0]     a_mag, b_mag, b_add, div_rem;
    logic [WIDTH:0]       mul_sum;
    logic                 div_qbit;
    logic [2*WIDTH-1:0]   mul_next, div_next, prod_fix;
    logic [WIDTH-1:0]     quot_fix, rem_fix;

`ifdef MDU_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // acc holds {upper, lower}: product-in-progress for multiply, {remainder, quotient} for divide.
    mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .part_rem (acc_q[2*WIDTH-1:WIDTH-1]),
        .divisor  (b_q),
        .next_rem (div_rem),
        .q_bit    (div_qbit)
    );

    always_comb begin
        op_signed = (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
        sa        = op_signed & operand_a[WIDTH-1];
        sb        = op_signed & operand_b[WIDTH-1];
        a_mag     = sa ? -operand_a : operand_a;
        b_mag     = sb ? -operand_b : operand_b;

        b_add     = acc_q[0] ? b_q : {WIDTH{1'b0}};
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_add};
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_next  = {div_rem, acc_q[WIDTH-2:0], div_qbit};

        prod_fix  = qsign_q ? -acc_q : acc_q;
        quot_fix  = qsign_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix   = rsign_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        divz_d   = divz_q;
        qsign_d  = qsign_q;
        rsign_d  = rsign_q;
        done_d   = 1'b0;

        case (state_q)
            MDU_IDLE: begin
                if (start) begin
                    case (op)
                        MDU_OP_MULT, MDU_OP_MULTU, MDU_OP_DIV, MDU_OP_DIVU: begin
                            acc_d    = {{WIDTH{1'b0}}, a_mag};
                            b_d      = b_mag;
                            cnt_d    = '0;
                            is_div_d = op[1];
                            divz_d   = 1'b0;
                            qsign_d  = sa ^ sb;
                            rsign_d  = sa;
                            state_d  = MDU_RUN;
                            // Divide by zero bypasses RUN; acc carries the final {hi, lo}.
                            if (op[1] && (operand_b == '0)) begin
                                divz_d  = 1'b1;
                                acc_d   = {operand_a, {WIDTH{1'b1}}};
                                state_d = MDU_FIX;
                            end
                        end
                        MDU_OP_MTHI: hi_d = operand_a;
                        MDU_OP_MTLO: lo_d = operand_a;
                        default: ;
                    endcase
                end
            end
            MDU_RUN: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = MDU_FIX;
                end
            end
            MDU_FIX: begin
                if (divz_q) begin
                    hi_d = acc_q[2*WIDTH-1:WIDTH];
                    lo_d = acc_q[WIDTH-1:0];
                end else if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = MDU_IDLE;
            end
            default: state_d = MDU_IDLE;
        endcase

        if (abort_req && (state_q != MDU_IDLE)) begin
            state_d = MDU_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= MDU_IDLE;
            acc_q    <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            divz_q   <= 1'b0;
            qsign_q  <= 1'b0;
            rsign_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            divz_q   <= divz_d;
            qsign_q  <= qsign_d;
            rsign_q  <= rsign_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != MDU_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed and random ops against an arithmetic reference.
// Latency: n/a.
// Backpressure: n/a.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] operand_a, operand_b;
    logic        busy, done;
    logic [31:0] hi, lo;
`ifdef MDU_ABORT_EN
    logic        abort = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
`ifdef MDU_ABORT_EN
        .abort     (abort),
`endif
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV '/' and '%' truncate toward zero, remainder takes dividend sign.
    function automatic void ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] eh, output logic [31:0] el);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        logic [63:0] p;
        case (o)
            3'd0: p = sa * sb;
            3'd1: p = {32'd0, a} * {32'd0, b};
            3'd2: p = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
            default: p = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
        endcase
        eh = p[63:32];
        el = p[31:0];
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] eh, el, h0, l0;
        int lat, done_at, busy_cnt;
        bit stable;
        ref_model(o, a, b, eh, el);
        lat = (o[1] && (b == 0)) ? 2 : 34;
        @(negedge clk);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        h0 = hi; l0 = lo;
        done_at = -1; busy_cnt = 0; stable = 1'b1;
        for (int c = 1; c <= 40 && done_at < 0; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_cnt++;
            if (done) done_at = c;
            else if (hi !== h0 || lo !== l0) stable = 1'b0;
        end
        chk({tag, " done_cycle"}, 64'(done_at), 64'(lat));
        chk({tag, " busy_cycles"}, 64'(busy_cnt), 64'(lat - 1));
        chk({tag, " hilo_stable"}, 64'(stable), 64'd1);
        chk({tag, " hi"}, 64'(hi), 64'(eh));
        chk({tag, " lo"}, 64'(lo), 64'(el));
    endtask

    initial begin
        logic [31:0] h0, l0, rb;
        logic [2:0]  ro;
        int          done_cnt, d1, d2;
        bit          no_done;

        reset = 1'b0; start = 1'b0; op = 3'd0; operand_a = '0; operand_b = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset hilo", {hi, lo}, 64'd0);
        reset = 1'b1;

        run_op(3'd1, 32'd7, 32'd6, "multu_7x6");
        run_op(3'd0, -32'sd3, 32'd5, "mult_m3x5");
        run_op(3'd0, 32'h8000_0000, 32'h8000_0000, "mult_min_sq");
        run_op(3'd3, 32'd100, 32'd7, "divu_100_7");
        run_op(3'd2, -32'sd7, 32'd2, "div_m7_2");
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(3'd2, 32'd5, 32'd0, "div_by_zero");
        run_op(3'd3, 32'hDEAD_BEEF, 32'd0, "divu_by_zero");

        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            run_op(ro, $urandom, rb, $sformatf("rand%0d_op%0d", i, ro));
        end

        // start held high: second request must wait for the done cycle.
        @(negedge clk);
        start = 1'b1; op = 3'd0; operand_a = 32'd2; operand_b = 32'd3;
        done_cnt = 0; d1 = -1; d2 = -1;
        for (int c = 1; c <= 75; c++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (d1 < 0) d1 = c; else d2 = c;
            end
            if (c == 34) chk("b2b busy_in_done_cycle", 64'(busy), 64'd0);
            if (c == 35) begin
                chk("b2b busy_after_accept", 64'(busy), 64'd1);
                start = 1'b0;
            end
        end
        chk("b2b done_count", 64'(done_cnt), 64'd2);
        chk("b2b first_done", 64'(d1), 64'd34);
        chk("b2b second_done", 64'(d2), 64'd68);
        chk("b2b hilo", {hi, lo}, 64'd6);

        @(negedge clk);
        h0 = hi;
        start = 1'b1; op = 3'd5; operand_a = 32'h1234;
        @(negedge clk);
        start = 1'b0;
        chk("mtlo lo", 64'(lo), 64'h1234);
        chk("mtlo hi_kept", 64'(hi), 64'(h0));
        chk("mtlo done", 64'(done), 64'd0);
        chk("mtlo busy", 64'(busy), 64'd0);
        start = 1'b1; op = 3'd4; operand_a = 32'hCAFE_F00D;
        @(negedge clk);
        start = 1'b0;
        chk("mthi hi", 64'(hi), 64'hCAFE_F00D);

        h0 = hi; l0 = lo;
        start = 1'b1; op = 3'd6; operand_a = 32'h5555; operand_b = 32'h7;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("undef_op busy", 64'(busy), 64'd0);
        chk("undef_op hilo", {hi, lo}, {h0, l0});

`ifdef MDU_ABORT_EN
        h0 = hi; l0 = lo;
        start = 1'b1; op = 3'd1; operand_a = 32'd9; operand_b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort busy", 64'(busy), 64'd0);
        no_done = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done) no_done = 1'b0;
        end
        chk("abort no_done", 64'(no_done), 64'd1);
        chk("abort hilo_kept", {hi, lo}, {h0, l0});
`endif

        // Reset mid-operation: hi/lo are non-zero beforehand.
        start = 1'b1; op = 3'd1; operand_a = 32'd11; operand_b = 32'd13;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("midreset busy", 64'(busy), 64'd0);
        chk("midreset hilo", {hi, lo}, 64'd0);
        no_done = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done) no_done = 1'b0;
        end
        chk("midreset no_done", 64'(no_done), 64'd1);

        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "after_reset_multu");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
